// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, instruction encodings and fetch FSM states.
package cpu_pkg;

    localparam int unsigned PC_W     = 16;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPCODE_W = 5;

    // Opcode 5'b01111 is unused by the ISA, so decode drives no controls for it.
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11111;

    localparam logic [INSTR_W-1:0] NOP_INSTR  = {OP_NOP,  27'h0};
    localparam logic [INSTR_W-1:0] HALT_INSTR = {OP_HALT, 27'h0};

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} hold register that keeps the fetch returning during a stall.
module fetch_skid_buf #(
    parameter int unsigned PC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            drain_i,
    input  logic            clear_i,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            valid_o,
    output logic [31:0]     instr_o,
    output logic [PC_W-1:0] pc_o
);
    import cpu_pkg::*;

    logic            valid_q;
    logic [31:0]     instr_q;
    logic [PC_W-1:0] pc_q;

    // Clear and drain take priority over load; payload only moves on load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (clear_i || drain_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// IF stage and IF/ID register: PC, imem request tracking, stall/redirect/halt handling.
module instr_fetch #(
    parameter int unsigned     PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            hlt,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_re,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr_ID,
    output logic [PC_W-1:0] pc_ID,
    output logic [PC_W-1:0] pc_plus1_ID,
    output logic            valid_ID,
    output logic            halted
);
    import cpu_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            req_valid_q, req_valid_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic [31:0]     instr_id_q, instr_id_d;
    logic [PC_W-1:0] pc_id_q, pc_id_d;
    logic            valid_id_q, valid_id_d;
    logic            halted_q, halted_d;

    logic            skid_load, skid_drain, skid_clear;
    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;

    logic            halt_ev;

    // A halt only counts when it comes from a real instruction in ID.
    assign halt_ev = hlt && valid_id_q;

    // Holds the returning word when a stall lands on an outstanding request.
    fetch_skid_buf #(
        .PC_W (PC_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (skid_clear),
        .instr_i (imem_rdata),
        .pc_i    (req_pc_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect beats halt, halt beats stall.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (redirect)                    state_d = ST_RUN;
                else if (halt_ev)                state_d = ST_HALT;
                else if (stall && req_valid_q)   state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (redirect)                    state_d = ST_RUN;
                else if (halt_ev)                state_d = ST_HALT;
                else if (!stall)                 state_d = ST_RUN;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    // Output and datapath next-value logic; everything holds unless an event moves it.
    always_comb begin
        imem_re     = 1'b0;
        pc_d        = pc_q;
        req_valid_d = req_valid_q;
        req_pc_d    = req_pc_q;
        instr_id_d  = instr_id_q;
        pc_id_d     = pc_id_q;
        valid_id_d  = valid_id_q;
        halted_d    = halted_q;
        skid_load   = 1'b0;
        skid_drain  = 1'b0;
        skid_clear  = 1'b0;

        unique case (state_q)
            ST_RUN, ST_HOLD: begin
                if (redirect) begin
                    // Squash: in-flight and skid data belong to the wrong path.
                    pc_d        = redirect_pc;
                    req_valid_d = 1'b0;
                    skid_clear  = 1'b1;
                    instr_id_d  = NOP_INSTR;
                    pc_id_d     = '0;
                    valid_id_d  = 1'b0;
                end else if (halt_ev) begin
                    req_valid_d = 1'b0;
                    skid_clear  = 1'b1;
                    instr_id_d  = NOP_INSTR;
                    pc_id_d     = '0;
                    valid_id_d  = 1'b0;
                    halted_d    = 1'b1;
                end else if (stall) begin
                    req_valid_d = 1'b0;
                    skid_load   = (state_q == ST_RUN) && req_valid_q;
                end else begin
                    imem_re     = 1'b1;
                    pc_d        = pc_q + PC_W'(1);
                    req_valid_d = 1'b1;
                    req_pc_d    = pc_q;
                    if (state_q == ST_HOLD) begin
                        instr_id_d = skid_instr;
                        pc_id_d    = skid_pc;
                        valid_id_d = skid_valid;
                        skid_drain = 1'b1;
                    end else if (req_valid_q) begin
                        instr_id_d = imem_rdata;
                        pc_id_d    = req_pc_q;
                        valid_id_d = 1'b1;
                    end else begin
                        instr_id_d = NOP_INSTR;
                        pc_id_d    = '0;
                        valid_id_d = 1'b0;
                    end
                end
            end
            default: begin
                imem_re = 1'b0;
            end
        endcase
    end

    // PC, request tracking and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            instr_id_q  <= NOP_INSTR;
            pc_id_q     <= '0;
            valid_id_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
            instr_id_q  <= instr_id_d;
            pc_id_q     <= pc_id_d;
            valid_id_q  <= valid_id_d;
            halted_q    <= halted_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_ID    = instr_id_q;
    assign pc_ID       = pc_id_q;
    assign pc_plus1_ID = pc_id_q + PC_W'(1);
    assign valid_ID    = valid_id_q;
    assign halted      = halted_q;

endmodule
